// File: rtl/npc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// npc_mem_arbiter
//
// Shares the core's single memory port between instruction fetch (IF,
// read-only) and the load/store unit (LS, read/write). Only one transaction
// is outstanding at a time. Simultaneous requests are resolved round-robin,
// and a response that never arrives is completed with an error after a
// programmable number of cycles.
//
// Parameters
//   ADDR_W   address width shared by IF, LS and the memory port
//   DATA_W   data width; byte mask is DATA_W/8 bits
//   TIMEOUT  cycles spent waiting for a response before an error completion
//            (0 disables the timeout, maximum 65535)
//
// Ports
//   clk, rst                      clock (posedge) and async active-high reset
//   if_req_valid/ready, if_addr   IF read request handshake
//   if_rsp_valid/data/err         IF completion (single-cycle valid pulse)
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask    LS request handshake (store when ls_wen=1)
//   ls_rsp_valid/data/err         LS completion (single-cycle valid pulse)
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask downstream request, fields held until accept
//   mem_rsp_valid, mem_rsp_data   downstream completion for reads and writes
// ---------------------------------------------------------------------------
module npc_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_rsp_err,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                ls_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam int STRB_W = DATA_W / 8;

    // Timer compare value; when the timeout is disabled the compare is
    // never enabled, so the wrapped value for TIMEOUT=0 is harmless.
    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    state_e      state;
    owner_e      owner;
    owner_e      last_grant;
    logic [15:0] timer;

    logic              grant_if;
    logic              grant_ls;
    logic              timeout_hit;
    logic              rsp_done;
    logic [DATA_W-1:0] rsp_data_next;
    logic              rsp_err_next;

    // Round-robin arbitration: a lone requester always wins; on a tie the
    // requester that did not win last time goes next.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE) begin
            grant_ls = ls_req_valid && (!if_req_valid || (last_grant == OWN_IF));
            grant_if = if_req_valid && (!ls_req_valid || (last_grant == OWN_LS));
        end
    end

    // Readys are forced low during reset so every output reads 0 while rst
    // is held, even if a requester is already presenting valid.
    assign if_req_ready = !rst && grant_if;
    assign ls_req_ready = !rst && grant_ls;

    // Completion source: a real response always beats a timeout landing in
    // the same cycle.
    always_comb begin
        timeout_hit   = 1'b0;
        rsp_done      = 1'b0;
        rsp_data_next = '0;
        rsp_err_next  = 1'b0;
        if (state == RESP) begin
            timeout_hit = TIMEOUT_EN && (timer == TIMEOUT_LAST) && !mem_rsp_valid;
            if (mem_rsp_valid) begin
                rsp_done      = 1'b1;
                rsp_data_next = mem_rsp_data;
            end else if (timeout_hit) begin
                rsp_done     = 1'b1;
                rsp_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            last_grant    <= OWN_IF;
            timer         <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            if_rsp_err    <= 1'b0;
            ls_rsp_valid  <= 1'b0;
            ls_rsp_data   <= '0;
            ls_rsp_err    <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle; data/err are held.
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        state         <= REQ;
                        owner         <= OWN_LS;
                        last_grant    <= OWN_LS;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= ls_addr;
                        mem_wen       <= ls_wen;
                        mem_wdata     <= ls_wdata;
                        mem_wmask     <= ls_wmask;
                    end else if (grant_if) begin
                        // Fetches are always plain reads.
                        state         <= REQ;
                        owner         <= OWN_IF;
                        last_grant    <= OWN_IF;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= if_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= {STRB_W{1'b0}};
                    end
                end

                REQ: begin
                    // A response seen here belongs to no transaction and is
                    // ignored; only the downstream accept moves us on.
                    if (mem_req_ready) begin
                        state         <= RESP;
                        mem_req_valid <= 1'b0;
                        timer         <= '0;
                    end
                end

                RESP: begin
                    if (timer != 16'hFFFF) begin
                        timer <= timer + 16'd1;
                    end
                    if (rsp_done) begin
                        state <= IDLE;
                        if (owner == OWN_LS) begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_data  <= rsp_data_next;
                            ls_rsp_err   <= rsp_err_next;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= rsp_data_next;
                            if_rsp_err   <= rsp_err_next;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_npc_mem_arbiter
//
// Directed bench for npc_mem_arbiter (TIMEOUT overridden to 8). The main
// initial block plays both requesters and the memory. Whenever it drives a
// memory response (or lets a timeout run out) it pushes the completion it
// expects, tagged with the cycle it must appear in, onto a scoreboard. A
// negedge monitor pops the entry in that cycle and checks routing, data and
// error; in every other cycle it requires both completion pulses to be low.
// ---------------------------------------------------------------------------
module tb_npc_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_addr;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          if_rsp_err;
    logic          ls_req_valid;
    logic          ls_req_ready;
    logic [AW-1:0] ls_addr;
    logic          ls_wen;
    logic [DW-1:0] ls_wdata;
    logic [SW-1:0] ls_wmask;
    logic          ls_rsp_valid;
    logic [DW-1:0] ls_rsp_data;
    logic          ls_rsp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    npc_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_addr      (ls_addr),
        .ls_wen       (ls_wen),
        .ls_wdata     (ls_wdata),
        .ls_wmask     (ls_wmask),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_data  (ls_rsp_data),
        .ls_rsp_err   (ls_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit          owner;     // 0 = IF, 1 = LS
        logic [63:0] data;
        bit          err;
        bit          chk_data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit ifv, input logic [63:0] ifa,
                                 input bit lsv, input logic [63:0] lsa,
                                 input bit wen, input logic [63:0] wd,
                                 input logic [7:0] wm);
        if_req_valid = ifv;
        if_addr      = ifa;
        ls_req_valid = lsv;
        ls_addr      = lsa;
        ls_wen       = wen;
        ls_wdata     = wd;
        ls_wmask     = wm;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctl"}, 64'({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                                        if_rsp_err, ls_rsp_err, mem_req_valid, mem_wen}), 64'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 64'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        checkOutput({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
        checkOutput({tag, "_if_rsp_data"}, if_rsp_data, 64'd0);
        checkOutput({tag, "_ls_rsp_data"}, ls_rsp_data, 64'd0);
    endtask

    task automatic checkBusyReadys();
        checkOutput("if_ready_busy", 64'(if_req_ready), 64'd0);
        checkOutput("ls_ready_busy", 64'(ls_req_ready), 64'd0);
    endtask

    // Called in the cycle right after a request handshake. Plays the memory:
    // holds ready low for readyDelay cycles, accepts, then either answers
    // after rspDelay RESP cycles or (rspDelay < 0) stays silent until the
    // timeout. Returns in the cycle where the completion pulse is visible.
    task automatic runMem(input int readyDelay, input int rspDelay, input bit spurious,
                          input bit owner, input logic [63:0] eAddr, input bit eWen,
                          input logic [63:0] eWdata, input logic [7:0] eWmask, input bit chkWdata,
                          input logic [63:0] rspData, input bit chkData);
        exp_t e;
        for (int i = 0; i <= readyDelay; i++) begin
            mem_req_ready = (i == readyDelay);
            mem_rsp_valid = spurious && (i == 0) && (readyDelay > 0);
            mem_rsp_data  = 64'hBAD0_BAD0;
            @(negedge clk);
            checkOutput("mem_req_valid_req", 64'(mem_req_valid), 64'd1);
            checkOutput("mem_addr", mem_addr, eAddr);
            checkOutput("mem_wen", 64'(mem_wen), 64'(eWen));
            checkOutput("mem_wmask", 64'(mem_wmask), 64'(eWmask));
            if (chkWdata) checkOutput("mem_wdata", mem_wdata, eWdata);
            checkBusyReadys();
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (rspDelay < 0) begin
            e.owner = owner; e.data = 64'd0; e.err = 1'b1; e.chk_data = 1'b1; e.cyc = cyc + TO;
            sbq.push_back(e);
            repeat (TO) begin
                @(negedge clk);
                checkOutput("mem_req_valid_resp", 64'(mem_req_valid), 64'd0);
                checkBusyReadys();
                tick();
            end
        end else begin
            repeat (rspDelay) begin
                @(negedge clk);
                checkOutput("mem_req_valid_resp", 64'(mem_req_valid), 64'd0);
                checkBusyReadys();
                tick();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rspData;
            e.owner = owner; e.data = rspData; e.err = 1'b0; e.chk_data = chkData; e.cyc = cyc + 1;
            sbq.push_back(e);
            @(negedge clk);
            checkOutput("mem_req_valid_resp", 64'(mem_req_valid), 64'd0);
            checkBusyReadys();
            tick();
            mem_rsp_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor: exact-cycle completion check, otherwise no pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                mon_e = sbq.pop_front();
                checkOutput("if_rsp_valid", 64'(if_rsp_valid), 64'(!mon_e.owner));
                checkOutput("ls_rsp_valid", 64'(ls_rsp_valid), 64'(mon_e.owner));
                if (mon_e.owner) begin
                    checkOutput("ls_rsp_err", 64'(ls_rsp_err), 64'(mon_e.err));
                    if (mon_e.chk_data) checkOutput("ls_rsp_data", ls_rsp_data, mon_e.data);
                end else begin
                    checkOutput("if_rsp_err", 64'(if_rsp_err), 64'(mon_e.err));
                    if (mon_e.chk_data) checkOutput("if_rsp_data", if_rsp_data, mon_e.data);
                end
            end else begin
                checkOutput("no_rsp_pulse", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        checkAllZero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Test 1: single IF read, minimum round trip
        $display("[TB] IF read, minimum latency");
        applyStimulus(1, 64'h8000_0000, 0, 64'd0, 0, 64'd0, 8'h00);
        @(negedge clk);
        checkOutput("t1_if_ready", 64'(if_req_ready), 64'd1);
        checkOutput("t1_ls_ready", 64'(ls_req_ready), 64'd0);
        tick();
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);
        runMem(0, 0, 0, 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 1'b0, 64'h1234, 1'b1);

        // Test 2: both requesters valid every cycle, grants alternate LS, IF, LS, IF
        $display("[TB] tied requests, round robin");
        applyStimulus(1, 64'h8000_0100, 1, 64'h8000_0200, 0, 64'h5555, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t2_ls_ready", 64'(ls_req_ready), 64'((i % 2) == 0));
            checkOutput("t2_if_ready", 64'(if_req_ready), 64'((i % 2) == 1));
            tick();
            if ((i % 2) == 0)
                runMem(0, 0, 0, 1'b1, 64'h8000_0200, 1'b0, 64'h5555, 8'hFF, 1'b1, 64'h1000 + 64'(i), 1'b1);
            else
                runMem(0, 0, 0, 1'b0, 64'h8000_0100, 1'b0, 64'd0, 8'h00, 1'b0, 64'h1000 + 64'(i), 1'b1);
        end
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);

        // Test 3: LS store with back-pressure; fields must stay stable
        $display("[TB] LS store with mem_req_ready low");
        applyStimulus(0, 64'd0, 1, 64'h8000_0010, 1, 64'hDEAD_BEEF, 8'h0F);
        @(negedge clk);
        checkOutput("t3_ls_ready", 64'(ls_req_ready), 64'd1);
        tick();
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);
        runMem(5, 0, 0, 1'b1, 64'h8000_0010, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1, 64'hABCD, 1'b0);

        // Test 4: IF read that times out, then a stray late response
        $display("[TB] timeout");
        applyStimulus(1, 64'h8000_0040, 0, 64'd0, 0, 64'd0, 8'h00);
        @(negedge clk);
        checkOutput("t4_if_ready", 64'(if_req_ready), 64'd1);
        tick();
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);
        runMem(0, -1, 0, 1'b0, 64'h8000_0040, 1'b0, 64'd0, 8'h00, 1'b0, 64'd0, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD;
        tick();
        mem_rsp_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("t4_if_err_hold", 64'(if_rsp_err), 64'd1);
        checkOutput("t4_if_data_hold", if_rsp_data, 64'd0);
        checkOutput("t4_ls_err_hold", 64'(ls_rsp_err), 64'd0);
        tick();

        // Test 5: reset while an LS load waits in RESP
        $display("[TB] reset mid-transaction");
        applyStimulus(0, 64'd0, 1, 64'h8000_0300, 0, 64'd0, 8'hFF);
        @(negedge clk);
        checkOutput("t5_ls_ready", 64'(ls_req_ready), 64'd1);
        tick();
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (2) tick();
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h77;
        @(negedge clk);
        checkAllZero("t5_reset");
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1, 64'h8000_0400, 1, 64'h8000_0500, 0, 64'd0, 8'hFF);
        @(negedge clk);
        checkOutput("t5_tie_ls_ready", 64'(ls_req_ready), 64'd1);
        checkOutput("t5_tie_if_ready", 64'(if_req_ready), 64'd0);
        tick();
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);
        runMem(0, 0, 0, 1'b1, 64'h8000_0500, 1'b0, 64'd0, 8'hFF, 1'b1, 64'h5A5A, 1'b1);

        // Test 6: spurious responses in IDLE and REQ are ignored
        $display("[TB] spurious responses");
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hEE;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        applyStimulus(1, 64'h8000_0600, 0, 64'd0, 0, 64'd0, 8'h00);
        @(negedge clk);
        checkOutput("t6_if_ready", 64'(if_req_ready), 64'd1);
        tick();
        applyStimulus(0, 64'd0, 0, 64'd0, 0, 64'd0, 8'h00);
        runMem(2, 1, 1, 1'b0, 64'h8000_0600, 1'b0, 64'd0, 8'h00, 1'b0, 64'hC0FFEE, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        checkOutput("t6_ls_data_hold", ls_rsp_data, 64'h5A5A);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
